cvxif_offload_ctrl: RTL and testbench
=====================================

Name: cvxif_offload_ctrl

Overview:
- Sequences instructions that the issue stage offloads to the CV-X-IF coprocessor.
- Holds each issue request stable through the coprocessor's valid/ready handshake, then emits exactly one commit or kill per accepted instruction.
- Tracks outstanding transaction IDs and routes coprocessor results, or illegal-instruction rejects, to a registered writeback port.
- Sits between issue_read_operands and the coprocessor, in place of the current purely combinational issue/commit glue.

Parameters:
- TRANS_ID_BITS, 3: width of the scoreboard transaction ID; the outstanding table has 2**TRANS_ID_BITS entries.
- XLEN, 64: register/operand width.
- NR_RS, 3: number of source operands forwarded per request.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- flush_i  in  1  pipeline flush (unissued/speculative instructions)
- req_valid_i  in  1  offload request from issue stage
- req_ready_o  out  1  controller can accept a request
- req_instr_i  in  32  instruction word
- req_id_i  in  TRANS_ID_BITS  scoreboard transaction ID
- req_rs_i  in  NR_RS*XLEN  operands, rs[0] in LSBs
- x_issue_valid_o  out  1  issue valid to coprocessor
- x_issue_ready_i  in  1  coprocessor issue ready
- x_issue_instr_o  out  32  held instruction
- x_issue_id_o  out  TRANS_ID_BITS  held ID
- x_issue_rs_o  out  NR_RS*XLEN  held operands
- x_issue_accept_i  in  1  coprocessor accepts instruction (sampled at handshake)
- x_issue_writeback_i  in  1  accepted instruction will return a result
- x_commit_valid_o  out  1  commit strobe
- x_commit_id_o  out  TRANS_ID_BITS  commit ID
- x_commit_kill_o  out  1  kill the committed ID
- x_result_valid_i  in  1  coprocessor result valid
- x_result_ready_o  out  1  result accepted
- x_result_id_i  in  TRANS_ID_BITS  result ID
- x_result_data_i  in  XLEN  result data
- wb_valid_o  out  1  writeback to scoreboard
- wb_id_o  out  TRANS_ID_BITS  writeback ID
- wb_data_o  out  XLEN  result data, or the instruction word zero-extended as tval when wb_ex_valid_o is set
- wb_ex_valid_o  out  1  illegal-instruction exception
- busy_o  out  1  state != IDLE, or any outstanding bit set

Behaviour:
- Reset: state=IDLE; hold registers, outstanding bitmap, kill_pending and all wb_* outputs cleared. Every output is 0 except req_ready_o=1 and x_result_ready_o=1.
- FSM has four states: IDLE, ISSUE, COMMIT, REJECT.
- IDLE
  - req_ready_o=1.
  - req_valid_i & !flush_i: capture instr/id/rs into the hold register, kill_pending=0, go to ISSUE.
  - req_valid_i with flush_i: request is dropped.
- ISSUE
  - x_issue_valid_o=1 and x_issue_* driven from the hold register.
  - Valid is never retracted and data stays stable until x_issue_ready_i.
  - flush_i in ISSUE sets kill_pending; valid stays asserted.
  - On handshake with accept=1: if writeback=1, set outstanding[id]; go to COMMIT.
  - On handshake with accept=0: go to REJECT, or to IDLE if kill_pending|flush_i.
- COMMIT
  - One cycle: x_commit_valid_o=1, x_commit_id_o=held id, x_commit_kill_o=kill_pending|flush_i.
  - On kill, clear outstanding[id].
  - Go to IDLE. Commit therefore always arrives exactly 1 cycle after the accepting handshake.
- REJECT
  - One cycle: loads the wb register with valid=1, ex_valid=1, id=held id, data=zero-extended instr.
  - With flush_i the wb load is suppressed.
  - Go to IDLE.
- Result path
  - x_result_ready_o=0 only in REJECT; otherwise 1.
  - Handshake with outstanding[id]=1: load the wb register with valid=1, ex_valid=0, data; clear outstanding[id].
  - Handshake with outstanding[id]=0: consumed silently, no writeback.
  - A result whose ID is set in the same cycle (accept, writeback=1) counts as outstanding (bypass).
- wb outputs are registered, latency 1 from the load cycle, high for exactly one cycle unless reloaded.
- flush_i
  - Clears all outstanding bits and the pending wb register load that cycle. A flush wins over any simultaneous result.
  - Exception: the instruction in COMMIT is killed per the COMMIT rule above.
- Simultaneous set and clear of the same outstanding bit: clear wins only on flush/kill.
- An asynchronous reset mid-handshake returns to IDLE immediately and emits no commit for the in-flight ID.

Decomposition:
- cvxif_pkg gains the state enum cvxif_ctrl_state_e (IDLE/ISSUE/COMMIT/REJECT) and localparam CVXIF_NR_IDS = 2**TRANS_ID_BITS.
- One sub-module, cvxif_outstanding_tracker: bitmap with set port, clear port, flush-all, combinational query(id) including the same-cycle bypass, and any_o.

Test Plan:
- Accept with writeback: req id=2, ready=1, accept=1, writeback=1 → commit id=2 kill=0 next cycle. Result id=2 data=0xDEAD → wb_valid=1 id=2 data=0xDEAD one cycle later; busy_o falls to 0.
- Backpressure: ready held 0 for 5 cycles → x_issue_valid_o and instr/id/rs stable throughout; req_ready_o=0; exactly one commit after ready=1.
- Reject: accept=0, instr=0x0000700B, id=5 → wb_valid=1, wb_ex_valid=1, wb_id=5, wb_data=0x700B; no commit emitted.
- Flush during ISSUE: flush_i pulsed while ready=0, then accept=1 writeback=1 → commit kill=1; a later result for that ID gives no wb_valid_o.
- Flush with 2 outstanding (ids 1, 3): flush_i → outstanding cleared; results for 1 and 3 are consumed (ready=1) with no writeback.
- Reset mid-ISSUE: rst_i asserted with valid=1 → next cycle x_issue_valid_o=0, req_ready_o=1, busy_o=0, no commit.

Source files
------------

// File: rtl/cvxif_pkg.sv
// Shared types and sizing for the CV-X-IF offload controller.
// The controller FSM walks IDLE -> ISSUE -> (COMMIT | REJECT) -> IDLE.
package cvxif_pkg;

    localparam int unsigned CVXIF_TRANS_ID_BITS = 3;
    localparam int unsigned CVXIF_NR_IDS        = 2 ** CVXIF_TRANS_ID_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        COMMIT = 2'd2,
        REJECT = 2'd3
    } cvxif_ctrl_state_e;

endpackage

// File: rtl/cvxif_outstanding_tracker.sv
// One bit per transaction ID marking coprocessor results still owed to the scoreboard.
// The query includes an ID being set this same cycle so a result racing its own issue is not lost.
module cvxif_outstanding_tracker #(
    parameter int unsigned ID_BITS = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               set_i,
    input  logic [ID_BITS-1:0] set_id_i,
    input  logic               clr_i,
    input  logic [ID_BITS-1:0] clr_id_i,
    input  logic               kill_i,
    input  logic [ID_BITS-1:0] kill_id_i,
    input  logic [ID_BITS-1:0] query_id_i,
    output logic               query_hit_o,
    output logic               any_o
);

    localparam int unsigned NR_IDS = 2 ** ID_BITS;

    logic [NR_IDS-1:0] bits;

    generate
        for (genvar gi = 0; gi < NR_IDS; gi++) begin : g_bit
            logic bit_reg;

            // Flush and kill beat a same-cycle set; a set beats a result-driven clear.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    bit_reg <= 1'b0;
                end else if (flush_i || (kill_i && (kill_id_i == ID_BITS'(gi)))) begin
                    bit_reg <= 1'b0;
                end else if (set_i && (set_id_i == ID_BITS'(gi))) begin
                    bit_reg <= 1'b1;
                end else if (clr_i && (clr_id_i == ID_BITS'(gi))) begin
                    bit_reg <= 1'b0;
                end
            end

            assign bits[gi] = bit_reg;
        end
    endgenerate

    assign query_hit_o = bits[query_id_i] | (set_i & (set_id_i == query_id_i));
    assign any_o       = |bits;

endmodule

// File: rtl/cvxif_offload_ctrl.sv
// Issue/commit sequencer between issue_read_operands and a CV-X-IF coprocessor.
// Holds one request through the issue handshake, then emits one commit or a reject writeback.
module cvxif_offload_ctrl
    import cvxif_pkg::*;
#(
    parameter int unsigned TRANS_ID_BITS = CVXIF_TRANS_ID_BITS,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned NR_RS         = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_instr_i,
    input  logic [TRANS_ID_BITS-1:0] req_id_i,
    input  logic [NR_RS*XLEN-1:0]    req_rs_i,
    output logic                     x_issue_valid_o,
    input  logic                     x_issue_ready_i,
    output logic [31:0]              x_issue_instr_o,
    output logic [TRANS_ID_BITS-1:0] x_issue_id_o,
    output logic [NR_RS*XLEN-1:0]    x_issue_rs_o,
    input  logic                     x_issue_accept_i,
    input  logic                     x_issue_writeback_i,
    output logic                     x_commit_valid_o,
    output logic [TRANS_ID_BITS-1:0] x_commit_id_o,
    output logic                     x_commit_kill_o,
    input  logic                     x_result_valid_i,
    output logic                     x_result_ready_o,
    input  logic [TRANS_ID_BITS-1:0] x_result_id_i,
    input  logic [XLEN-1:0]          x_result_data_i,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_id_o,
    output logic [XLEN-1:0]          wb_data_o,
    output logic                     wb_ex_valid_o,
    output logic                     busy_o
);

    cvxif_ctrl_state_e state_reg, state_next;

    logic [31:0]              hold_instr_reg;
    logic [TRANS_ID_BITS-1:0] hold_id_reg;
    logic [NR_RS*XLEN-1:0]    hold_rs_reg;
    logic                     kill_pending_reg;

    logic                     wb_valid_reg;
    logic                     wb_ex_reg;
    logic [TRANS_ID_BITS-1:0] wb_id_reg;
    logic [XLEN-1:0]          wb_data_reg;

    logic capture;
    logic issue_hs;
    logic set_en;
    logic kill_en;
    logic result_hs;
    logic result_hit;
    logic any_outstanding;
    logic wb_load_result;
    logic wb_load_reject;

    assign capture   = (state_reg == IDLE) && req_valid_i && !flush_i;
    assign issue_hs  = (state_reg == ISSUE) && x_issue_ready_i;
    assign set_en    = issue_hs && x_issue_accept_i && x_issue_writeback_i;
    assign kill_en   = (state_reg == COMMIT) && (kill_pending_reg || flush_i);
    assign result_hs = x_result_valid_i && x_result_ready_o;

    // A flush cancels any writeback that would otherwise load this cycle.
    assign wb_load_result = result_hs && result_hit && !flush_i;
    assign wb_load_reject = (state_reg == REJECT) && !flush_i;

    cvxif_outstanding_tracker #(
        .ID_BITS (TRANS_ID_BITS)
    ) u_tracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .set_i       (set_en),
        .set_id_i    (hold_id_reg),
        .clr_i       (result_hs && result_hit),
        .clr_id_i    (x_result_id_i),
        .kill_i      (kill_en),
        .kill_id_i   (hold_id_reg),
        .query_id_i  (x_result_id_i),
        .query_hit_o (result_hit),
        .any_o       (any_outstanding)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (x_issue_ready_i) begin
                    if (x_issue_accept_i) begin
                        state_next = COMMIT;
                    end else if (kill_pending_reg || flush_i) begin
                        state_next = IDLE;
                    end else begin
                        state_next = REJECT;
                    end
                end
            end
            COMMIT:  state_next = IDLE;
            REJECT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o      = 1'b0;
        x_issue_valid_o  = 1'b0;
        x_commit_valid_o = 1'b0;
        x_commit_kill_o  = 1'b0;
        x_result_ready_o = 1'b1;
        case (state_reg)
            IDLE:   req_ready_o = 1'b1;
            ISSUE:  x_issue_valid_o = 1'b1;
            COMMIT: begin
                x_commit_valid_o = 1'b1;
                x_commit_kill_o  = kill_pending_reg || flush_i;
            end
            REJECT: x_result_ready_o = 1'b0;
            default: req_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_instr_reg   <= '0;
            hold_id_reg      <= '0;
            hold_rs_reg      <= '0;
            kill_pending_reg <= 1'b0;
        end else if (capture) begin
            hold_instr_reg   <= req_instr_i;
            hold_id_reg      <= req_id_i;
            hold_rs_reg      <= req_rs_i;
            kill_pending_reg <= 1'b0;
        end else if ((state_reg == ISSUE) && flush_i) begin
            kill_pending_reg <= 1'b1;
        end
    end

    // Result and reject loads never coincide: results are back-pressured in REJECT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_reg <= 1'b0;
            wb_ex_reg    <= 1'b0;
            wb_id_reg    <= '0;
            wb_data_reg  <= '0;
        end else begin
            wb_valid_reg <= wb_load_result || wb_load_reject;
            wb_ex_reg    <= wb_load_reject;
            if (wb_load_reject) begin
                wb_id_reg   <= hold_id_reg;
                wb_data_reg <= XLEN'(hold_instr_reg);
            end else if (wb_load_result) begin
                wb_id_reg   <= x_result_id_i;
                wb_data_reg <= x_result_data_i;
            end
        end
    end

    assign x_issue_instr_o = hold_instr_reg;
    assign x_issue_id_o    = hold_id_reg;
    assign x_issue_rs_o    = hold_rs_reg;
    assign x_commit_id_o   = hold_id_reg;

    assign wb_valid_o    = wb_valid_reg;
    assign wb_ex_valid_o = wb_ex_reg;
    assign wb_id_o       = wb_id_reg;
    assign wb_data_o     = wb_data_reg;

    assign busy_o = (state_reg != IDLE) || any_outstanding;

endmodule

// File: tb/tb_cvxif_offload_ctrl.sv
// Bench for cvxif_offload_ctrl: directed vector table, hand sequences for
// backpressure and reset, then randomized traffic against a transaction-level model.
module tb_cvxif_offload_ctrl;

    localparam int IDB  = 3;
    localparam int XLEN = 64;
    localparam int NRS  = 3;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [31:0]      req_instr_i;
    logic [IDB-1:0]   req_id_i;
    logic [NRS*XLEN-1:0] req_rs_i;
    logic             x_issue_valid_o;
    logic             x_issue_ready_i;
    logic [31:0]      x_issue_instr_o;
    logic [IDB-1:0]   x_issue_id_o;
    logic [NRS*XLEN-1:0] x_issue_rs_o;
    logic             x_issue_accept_i;
    logic             x_issue_writeback_i;
    logic             x_commit_valid_o;
    logic [IDB-1:0]   x_commit_id_o;
    logic             x_commit_kill_o;
    logic             x_result_valid_i;
    logic             x_result_ready_o;
    logic [IDB-1:0]   x_result_id_i;
    logic [XLEN-1:0]  x_result_data_i;
    logic             wb_valid_o;
    logic [IDB-1:0]   wb_id_o;
    logic [XLEN-1:0]  wb_data_o;
    logic             wb_ex_valid_o;
    logic             busy_o;

    always #5 clk = ~clk;

    cvxif_offload_ctrl #(
        .TRANS_ID_BITS (IDB),
        .XLEN          (XLEN),
        .NR_RS         (NRS)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_instr_i         (req_instr_i),
        .req_id_i            (req_id_i),
        .req_rs_i            (req_rs_i),
        .x_issue_valid_o     (x_issue_valid_o),
        .x_issue_ready_i     (x_issue_ready_i),
        .x_issue_instr_o     (x_issue_instr_o),
        .x_issue_id_o        (x_issue_id_o),
        .x_issue_rs_o        (x_issue_rs_o),
        .x_issue_accept_i    (x_issue_accept_i),
        .x_issue_writeback_i (x_issue_writeback_i),
        .x_commit_valid_o    (x_commit_valid_o),
        .x_commit_id_o       (x_commit_id_o),
        .x_commit_kill_o     (x_commit_kill_o),
        .x_result_valid_i    (x_result_valid_i),
        .x_result_ready_o    (x_result_ready_o),
        .x_result_id_i       (x_result_id_i),
        .x_result_data_i     (x_result_data_i),
        .wb_valid_o          (wb_valid_o),
        .wb_id_o             (wb_id_o),
        .wb_data_o           (wb_data_o),
        .wb_ex_valid_o       (wb_ex_valid_o),
        .busy_o              (busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string          name;
        logic           rv, fl, ir, ac, wbk, resv;
        logic [IDB-1:0] id, rid;
        logic [31:0]    instr;
        logic [63:0]    rdata;
        logic           e_rr, e_iv, e_cv, e_ck, e_resr, e_wv, e_wex, e_busy;
        logic [IDB-1:0] e_cid, e_wid;
        logic [63:0]    e_wd;
    } vec_t;

    function automatic vec_t v(input string n, input logic rv, fl, input logic [IDB-1:0] id,
                               input logic [31:0] ins, input logic ir, ac, wbk, resv,
                               input logic [IDB-1:0] rid, input logic [63:0] rd,
                               input logic rr, iv, cv, input logic [IDB-1:0] cid, input logic ck,
                               input logic resr, wv, wex, input logic [IDB-1:0] wid,
                               input logic [63:0] wd, input logic busy);
        vec_t r;
        r.name = n; r.rv = rv; r.fl = fl; r.id = id; r.instr = ins; r.ir = ir; r.ac = ac;
        r.wbk = wbk; r.resv = resv; r.rid = rid; r.rdata = rd;
        r.e_rr = rr; r.e_iv = iv; r.e_cv = cv; r.e_cid = cid; r.e_ck = ck; r.e_resr = resr;
        r.e_wv = wv; r.e_wex = wex; r.e_wid = wid; r.e_wd = wd; r.e_busy = busy;
        return r;
    endfunction

    task automatic drive_idle();
        flush_i = 0; req_valid_i = 0; req_instr_i = '0; req_id_i = '0; req_rs_i = '0;
        x_issue_ready_i = 0; x_issue_accept_i = 0; x_issue_writeback_i = 0;
        x_result_valid_i = 0; x_result_id_i = '0; x_result_data_i = '0;
    endtask

    // Transaction-level reference: one held request, a pending commit or reject, a set of owed IDs.
    bit              m_held, m_commit_due, m_reject_due, m_killed;
    logic [31:0]     m_instr;
    logic [IDB-1:0]  m_id;
    logic [NRS*XLEN-1:0] m_rs;
    bit              m_owed[8];
    bit              e_wbv, e_wbex;
    logic [IDB-1:0]  e_wbid;
    logic [63:0]     e_wbd;

    task automatic model_reset();
        m_held = 0; m_commit_due = 0; m_reject_due = 0; m_killed = 0;
        m_instr = '0; m_id = '0; m_rs = '0;
        foreach (m_owed[i]) m_owed[i] = 0;
        e_wbv = 0; e_wbex = 0; e_wbid = '0; e_wbd = '0;
    endtask

    function automatic bit model_busy();
        bit b = m_held || m_commit_due || m_reject_due;
        foreach (m_owed[i]) b |= m_owed[i];
        return b;
    endfunction

    task automatic model_check(input int cyc);
        bit idle_m = !(m_held || m_commit_due || m_reject_due);
        chk($sformatf("rnd%0d.req_ready", cyc), req_ready_o, idle_m);
        chk($sformatf("rnd%0d.issue_valid", cyc), x_issue_valid_o, m_held);
        if (m_held) begin
            chk($sformatf("rnd%0d.issue_instr", cyc), x_issue_instr_o, m_instr);
            chk($sformatf("rnd%0d.issue_id", cyc), x_issue_id_o, m_id);
            chk($sformatf("rnd%0d.issue_rs", cyc), x_issue_rs_o, m_rs);
        end
        chk($sformatf("rnd%0d.commit_valid", cyc), x_commit_valid_o, m_commit_due);
        chk($sformatf("rnd%0d.commit_kill", cyc), x_commit_kill_o,
            m_commit_due && (m_killed || flush_i));
        if (m_commit_due) chk($sformatf("rnd%0d.commit_id", cyc), x_commit_id_o, m_id);
        chk($sformatf("rnd%0d.result_ready", cyc), x_result_ready_o, !m_reject_due);
        chk($sformatf("rnd%0d.wb_valid", cyc), wb_valid_o, e_wbv);
        chk($sformatf("rnd%0d.wb_ex", cyc), wb_ex_valid_o, e_wbex);
        if (e_wbv) begin
            chk($sformatf("rnd%0d.wb_id", cyc), wb_id_o, e_wbid);
            chk($sformatf("rnd%0d.wb_data", cyc), wb_data_o, e_wbd);
        end
        chk($sformatf("rnd%0d.busy", cyc), busy_o, model_busy());
    endtask

    task automatic model_step();
        bit hs_accept_wb = m_held && x_issue_ready_i && x_issue_accept_i && x_issue_writeback_i;
        bit res_take = x_result_valid_i && !m_reject_due;
        bit hit = m_owed[x_result_id_i] || (hs_accept_wb && (m_id == x_result_id_i));
        e_wbv = 0; e_wbex = 0;
        if (!flush_i && res_take && hit) begin
            e_wbv = 1; e_wbid = x_result_id_i; e_wbd = x_result_data_i;
        end
        if (!flush_i && m_reject_due) begin
            e_wbv = 1; e_wbex = 1; e_wbid = m_id; e_wbd = {32'h0, m_instr};
        end
        if (res_take && hit) m_owed[x_result_id_i] = 0;
        if (hs_accept_wb) m_owed[m_id] = 1;
        if (m_commit_due && (m_killed || flush_i)) m_owed[m_id] = 0;
        if (flush_i) foreach (m_owed[i]) m_owed[i] = 0;
        if (m_commit_due) begin
            m_commit_due = 0;
        end else if (m_reject_due) begin
            m_reject_due = 0;
        end else if (m_held) begin
            if (flush_i) m_killed = 1;
            if (x_issue_ready_i) begin
                m_held = 0;
                if (x_issue_accept_i) m_commit_due = 1;
                else if (!m_killed) m_reject_due = 1;
            end
        end else if (req_valid_i && !flush_i) begin
            m_held = 1; m_killed = 0;
            m_instr = req_instr_i; m_id = req_id_i; m_rs = req_rs_i;
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t tbl[$];
    logic [31:0] bp_instr;
    logic [NRS*XLEN-1:0] bp_rs;
    int ncommit;

    initial begin
        // name                rv fl id instr          ir ac wb rs rid rdata       rr iv cv cid ck resr wv wex wid wd      busy
        tbl.push_back(v("a_req",     1,0,2,32'h0A0B,    0,0,0,0,0,64'h0,        1,0,0,0,0,1,0,0,0,64'h0,    0));
        tbl.push_back(v("a_hs",      0,0,0,32'h0,       1,1,1,0,0,64'h0,        0,1,0,0,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("a_commit",  0,0,0,32'h0,       0,0,0,0,0,64'h0,        0,0,1,2,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("a_result",  0,0,0,32'h0,       0,0,0,1,2,64'hDEAD,     1,0,0,0,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("a_wb",      0,0,0,32'h0,       0,0,0,0,0,64'h0,        1,0,0,0,0,1,1,0,2,64'hDEAD, 0));
        tbl.push_back(v("a_quiet",   0,0,0,32'h0,       0,0,0,0,0,64'h0,        1,0,0,0,0,1,0,0,0,64'h0,    0));
        tbl.push_back(v("r_req",     1,0,5,32'h700B,    0,0,0,0,0,64'h0,        1,0,0,0,0,1,0,0,0,64'h0,    0));
        tbl.push_back(v("r_hs",      0,0,0,32'h0,       1,0,0,0,0,64'h0,        0,1,0,0,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("r_reject",  0,0,0,32'h0,       0,0,0,0,0,64'h0,        0,0,0,0,0,0,0,0,0,64'h0,    1));
        tbl.push_back(v("r_wb",      0,0,0,32'h0,       0,0,0,0,0,64'h0,        1,0,0,0,0,1,1,1,5,64'h700B, 0));
        tbl.push_back(v("f_req",     1,0,4,32'h1234,    0,0,0,0,0,64'h0,        1,0,0,0,0,1,0,0,0,64'h0,    0));
        tbl.push_back(v("f_flush",   0,1,0,32'h0,       0,0,0,0,0,64'h0,        0,1,0,0,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("f_hs",      0,0,0,32'h0,       1,1,1,0,0,64'h0,        0,1,0,0,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("f_commit",  0,0,0,32'h0,       0,0,0,0,0,64'h0,        0,0,1,4,1,1,0,0,0,64'h0,    1));
        tbl.push_back(v("f_result",  0,0,0,32'h0,       0,0,0,1,4,64'h1234,     1,0,0,0,0,1,0,0,0,64'h0,    0));
        tbl.push_back(v("f_quiet",   0,0,0,32'h0,       0,0,0,0,0,64'h0,        1,0,0,0,0,1,0,0,0,64'h0,    0));
        tbl.push_back(v("o_req1",    1,0,1,32'h11,      0,0,0,0,0,64'h0,        1,0,0,0,0,1,0,0,0,64'h0,    0));
        tbl.push_back(v("o_hs1",     0,0,0,32'h0,       1,1,1,0,0,64'h0,        0,1,0,0,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("o_commit1", 0,0,0,32'h0,       0,0,0,0,0,64'h0,        0,0,1,1,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("o_req3",    1,0,3,32'h33,      0,0,0,0,0,64'h0,        1,0,0,0,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("o_hs3",     0,0,0,32'h0,       1,1,1,0,0,64'h0,        0,1,0,0,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("o_commit3", 0,0,0,32'h0,       0,0,0,0,0,64'h0,        0,0,1,3,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("o_flush",   0,1,0,32'h0,       0,0,0,0,0,64'h0,        1,0,0,0,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("o_res1",    0,0,0,32'h0,       0,0,0,1,1,64'hAAAA,     1,0,0,0,0,1,0,0,0,64'h0,    0));
        tbl.push_back(v("o_res3",    0,0,0,32'h0,       0,0,0,1,3,64'hBBBB,     1,0,0,0,0,1,0,0,0,64'h0,    0));
        tbl.push_back(v("o_quiet",   0,0,0,32'h0,       0,0,0,0,0,64'h0,        1,0,0,0,0,1,0,0,0,64'h0,    0));
        tbl.push_back(v("b_req",     1,0,6,32'h66,      0,0,0,0,0,64'h0,        1,0,0,0,0,1,0,0,0,64'h0,    0));
        tbl.push_back(v("b_hs_res",  0,0,0,32'h0,       1,1,1,1,6,64'hBEEF,     0,1,0,0,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("b_commit",  0,0,0,32'h0,       0,0,0,0,0,64'h0,        0,0,1,6,0,1,1,0,6,64'hBEEF, 1));
        tbl.push_back(v("b_res2",    0,0,0,32'h0,       0,0,0,1,6,64'h77,       1,0,0,0,0,1,0,0,0,64'h0,    1));
        tbl.push_back(v("b_wb2",     0,0,0,32'h0,       0,0,0,0,0,64'h0,        1,0,0,0,0,1,1,0,6,64'h77,   0));

        rst_i = 1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.req_ready", req_ready_o, 1);
        chk("reset.result_ready", x_result_ready_o, 1);
        chk("reset.issue_valid", x_issue_valid_o, 0);
        chk("reset.commit_valid", x_commit_valid_o, 0);
        chk("reset.wb_valid", wb_valid_o, 0);
        chk("reset.busy", busy_o, 0);
        @(posedge clk); #1;
        rst_i = 0;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            req_valid_i = tbl[i].rv; flush_i = tbl[i].fl; req_id_i = tbl[i].id;
            req_instr_i = tbl[i].instr; req_rs_i = {3{64'(tbl[i].id) ^ 64'hA5A5_0000_0000_0000}};
            x_issue_ready_i = tbl[i].ir; x_issue_accept_i = tbl[i].ac;
            x_issue_writeback_i = tbl[i].wbk; x_result_valid_i = tbl[i].resv;
            x_result_id_i = tbl[i].rid; x_result_data_i = tbl[i].rdata;
            @(negedge clk);
            chk({tbl[i].name, ".req_ready"}, req_ready_o, tbl[i].e_rr);
            chk({tbl[i].name, ".issue_valid"}, x_issue_valid_o, tbl[i].e_iv);
            chk({tbl[i].name, ".commit_valid"}, x_commit_valid_o, tbl[i].e_cv);
            if (tbl[i].e_cv) chk({tbl[i].name, ".commit_id"}, x_commit_id_o, tbl[i].e_cid);
            chk({tbl[i].name, ".commit_kill"}, x_commit_kill_o, tbl[i].e_ck);
            chk({tbl[i].name, ".result_ready"}, x_result_ready_o, tbl[i].e_resr);
            chk({tbl[i].name, ".wb_valid"}, wb_valid_o, tbl[i].e_wv);
            chk({tbl[i].name, ".wb_ex"}, wb_ex_valid_o, tbl[i].e_wex);
            if (tbl[i].e_wv) begin
                chk({tbl[i].name, ".wb_id"}, wb_id_o, tbl[i].e_wid);
                chk({tbl[i].name, ".wb_data"}, wb_data_o, tbl[i].e_wd);
            end
            chk({tbl[i].name, ".busy"}, busy_o, tbl[i].e_busy);
        end

        // Backpressure: request inputs are scrambled while the coprocessor stalls.
        bp_instr = 32'hC0DE_F00D;
        bp_rs = {64'h3333_4444_5555_6666, 64'h1111_2222_3333_4444, 64'h0F0F_F0F0_1234_5678};
        @(posedge clk); #1;
        drive_idle();
        req_valid_i = 1; req_id_i = 3'd7; req_instr_i = bp_instr; req_rs_i = bp_rs;
        @(posedge clk); #1;
        req_valid_i = 0; req_id_i = 3'd0; req_instr_i = ~bp_instr; req_rs_i = ~bp_rs;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d.issue_valid", k), x_issue_valid_o, 1);
            chk($sformatf("bp%0d.issue_instr", k), x_issue_instr_o, bp_instr);
            chk($sformatf("bp%0d.issue_id", k), x_issue_id_o, 3'd7);
            chk($sformatf("bp%0d.issue_rs", k), x_issue_rs_o, bp_rs);
            chk($sformatf("bp%0d.req_ready", k), req_ready_o, 0);
            chk($sformatf("bp%0d.commit_valid", k), x_commit_valid_o, 0);
            @(posedge clk); #1;
        end
        x_issue_ready_i = 1; x_issue_accept_i = 1; x_issue_writeback_i = 0;
        ncommit = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (x_commit_valid_o) begin
                ncommit++;
                chk("bp.commit_id", x_commit_id_o, 3'd7);
                chk("bp.commit_kill", x_commit_kill_o, 0);
            end
            @(posedge clk); #1;
            x_issue_ready_i = 0;
        end
        chk("bp.commit_count", ncommit, 1);
        @(negedge clk);
        chk("bp.busy_after", busy_o, 0);

        // Asynchronous reset while an issue is held.
        @(posedge clk); #1;
        drive_idle();
        req_valid_i = 1; req_id_i = 3'd2; req_instr_i = 32'h0000_2222;
        @(posedge clk); #1;
        req_valid_i = 0;
        @(negedge clk);
        chk("rst.pre_issue_valid", x_issue_valid_o, 1);
        #2;
        rst_i = 1;
        #1;
        chk("rst.issue_valid", x_issue_valid_o, 0);
        chk("rst.req_ready", req_ready_o, 1);
        chk("rst.busy", busy_o, 0);
        chk("rst.commit_valid", x_commit_valid_o, 0);
        @(posedge clk); #1;
        rst_i = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_post%0d.commit_valid", k), x_commit_valid_o, 0);
            chk($sformatf("rst_post%0d.issue_valid", k), x_issue_valid_o, 0);
        end

        // Randomized traffic against the reference model, from a clean reset.
        @(posedge clk); #1;
        drive_idle();
        rst_i = 1;
        model_reset();
        @(posedge clk); #1;
        rst_i = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            req_valid_i         = 1'($urandom_range(0, 1));
            flush_i             = ($urandom_range(0, 15) == 0);
            req_instr_i         = $urandom();
            req_id_i            = 3'($urandom_range(0, 7));
            req_rs_i            = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            x_issue_ready_i     = ($urandom_range(0, 2) != 0);
            x_issue_accept_i    = ($urandom_range(0, 3) != 0);
            x_issue_writeback_i = 1'($urandom_range(0, 1));
            x_result_valid_i    = ($urandom_range(0, 2) == 0);
            x_result_id_i       = 3'($urandom_range(0, 7));
            x_result_data_i     = {$urandom(), $urandom()};
            @(negedge clk);
            model_check(cyc);
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
